// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } adder_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR of their carries.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder used as the building block of full_adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit pair per cycle, LSB first, result shifted in from the MSB end.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done,
    output adder_state_e     state
);

    // Handshake: start is sampled only in IDLE and is never queued; busy is high
    // through SHIFT, and done pulses for one cycle when Sum/Cout become valid.

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    Sum   <= {fa_sum, Sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        Cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 using immediate assertions.
module tb_serial_adder;
    import adder_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   A;
    logic [7:0]   B;
    logic         Cin;
    logic [7:0]   Sum;
    logic         Cout;
    logic         busy;
    logic         done;
    adder_state_e state;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one addition; operands are scrambled right after acceptance.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        logic [8:0] exp;
        exp   = {1'b0, a} + {1'b0, b} + {8'b0, c};
        A     = a;
        B     = b;
        Cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        Cin   = 1'($urandom);
        check("busy_shift", {31'b0, busy}, 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("latency", n + 1, 32'd9);
        check("sum", {24'b0, Sum}, {24'b0, exp[7:0]});
        check("cout", {31'b0, Cout}, {31'b0, exp[8]});
        check("busy_in_done", {31'b0, busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        int cyc;
        int last_cyc;
        int k;
        logic [7:0] cap_sum;
        logic       cap_cout;
        logic [8:0] exp;
        logic       after_done;

        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        Cin   = 1'b0;
        tick();
        tick();
        check("rst_sum", {24'b0, Sum}, 32'd0);
        check("rst_cout", {31'b0, Cout}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_state", {30'b0, state}, {30'b0, IDLE});
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_hold_state", {30'b0, state}, {30'b0, IDLE});
        check("idle_hold_busy", {31'b0, busy}, 32'd0);

        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h5A, 8'hA5, 1'b1);
        run_op(8'h12, 8'h34, 1'b1);
        tick();
        tick();
        tick();
        check("hold_sum", {24'b0, Sum}, 32'h47);
        check("hold_cout", {31'b0, Cout}, 32'd0);

        // A second start during SHIFT must not disturb or restart the addition.
        A     = 8'h3C;
        B     = 8'h42;
        Cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A     = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses   = 0;
        cap_sum  = 8'h00;
        cap_cout = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                cap_sum  = Sum;
                cap_cout = Cout;
            end
        end
        check("ignored_start_pulses", pulses, 32'd1);
        check("ignored_start_sum", {24'b0, cap_sum}, 32'h7E);
        check("ignored_start_cout", {31'b0, cap_cout}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        A     = 8'h77;
        B     = 8'h11;
        Cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_sum", {24'b0, Sum}, 32'd0);
        check("midrst_cout", {31'b0, Cout}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_state", {30'b0, state}, {30'b0, IDLE});
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("midrst_no_done", pulses, 32'd0);
        run_op(8'h12, 8'h34, 1'b1);

        // start held high: three back-to-back operations, new operands after each done.
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h101);
        exp_q.push_back(9'h1FD);
        A          = 8'h10;
        B          = 8'h20;
        Cin        = 1'b0;
        start      = 1'b1;
        cyc        = 0;
        last_cyc   = -1;
        k          = 0;
        after_done = 1'b0;
        while (k < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (after_done) begin
                check("b2b_idle_busy", {31'b0, busy}, 32'd0);
                check("b2b_idle_done", {31'b0, done}, 32'd0);
                after_done = 1'b0;
            end
            if (done === 1'b1) begin
                exp = exp_q.pop_front();
                check("b2b_sum", {24'b0, Sum}, {24'b0, exp[7:0]});
                check("b2b_cout", {31'b0, Cout}, {31'b0, exp[8]});
                check("b2b_done_busy", {31'b0, busy}, 32'd0);
                if (last_cyc >= 0) check("b2b_period", cyc - last_cyc, 32'd10);
                last_cyc   = cyc;
                after_done = 1'b1;
                k++;
                if (k == 1) begin
                    A   = 8'h80;
                    B   = 8'h80;
                    Cin = 1'b1;
                end else if (k == 2) begin
                    A   = 8'hFE;
                    B   = 8'hFE;
                    Cin = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_count", k, 32'd3);
        tick();
        check("b2b_last_idle_busy", {31'b0, busy}, 32'd0);
        tick();
        tick();

        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
